// File: rtl/isqrt_pipe_with_valid.sv
// Fully pipelined unsigned integer square root: one root bit per stage, one valid bit per stage.
// Optional build macro ISQRT_REMAINDER_EN exports the final remainder on out_rem.
module isqrt_pipe_with_valid #(
  parameter int width = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  input  logic [width-1:0]     in_data,
  output logic                 out_vld,
  output logic [width/2-1:0]   out_data
`ifdef ISQRT_REMAINDER_EN
  ,
  output logic [width/2:0]     out_rem
`endif
);
  localparam int n = width / 2;

  if ((width % 2) != 0 || width < 4) begin : g_width_check
    $error("isqrt_pipe_with_valid: width must be even and >= 4, got %0d", width);
  end

  // Valid-only stream: no ready, no stall. A stage's data registers load only when
  // that stage's incoming valid is 1, so idle stages hold their last result.
  logic [n-1:0] vld_q;
  logic [n-1:0] vld_d;

  assign vld_d   = {vld_q[n-2:0], in_vld};
  assign out_vld = vld_q[n-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Per-stage registered state, and the values each stage sees on its input.
  logic [n-1:0]     q_s    [n];
  logic [n+1:0]     r_s    [n-1];
  logic [width-1:0] x_s    [n-1];
  logic [n-1:0]     q_in_s [n];
  logic [n+1:0]     r_in_s [n];
  logic [width-1:0] x_in_s [n];

  assign q_in_s[0] = '0;
  assign r_in_s[0] = '0;
  assign x_in_s[0] = in_data;

  for (genvar i = 1; i < n; i++) begin : g_link
    assign q_in_s[i] = q_s[i-1];
    assign r_in_s[i] = r_s[i-1];
    assign x_in_s[i] = x_s[i-1];
  end

  for (genvar i = 0; i < n; i++) begin : g_stg
    logic [n+1:0] r_sh;
    logic [n+1:0] t;
    logic         ge;
    logic [n-1:0] q_d;
    logic [n-1:0] q_q;

    // The unconsumed operand bits are kept left-aligned, so the next digit is always the top pair.
    assign r_sh = (r_in_s[i] << 2) | {{n{1'b0}}, x_in_s[i][width-1 -: 2]};
    assign t    = {q_in_s[i], 2'b01};
    assign ge   = (r_sh >= t);
    assign q_d  = (q_in_s[i] << 1) | {{(n-1){1'b0}}, ge};

    always_ff @(posedge clk) begin
      if (vld_d[i]) begin
        q_q <= q_d;
      end
    end

    assign q_s[i] = q_q;

    if (i < n-1) begin : g_mid
      logic [n+1:0]     r_d;
      logic [n+1:0]     r_q;
      logic [width-1:0] x_q;

      assign r_d = ge ? (r_sh - t) : r_sh;

      always_ff @(posedge clk) begin
        if (vld_d[i]) begin
          r_q <= r_d;
          x_q <= x_in_s[i] << 2;
        end
      end

      assign r_s[i] = r_q;
      assign x_s[i] = x_q;
    end else begin : g_last
`ifdef ISQRT_REMAINDER_EN
      // Final remainder never exceeds 2*root, so n+1 bits suffice.
      logic [n:0] rem_d;
      logic [n:0] rem_q;

      assign rem_d = (n+1)'(ge ? (r_sh - t) : r_sh);

      always_ff @(posedge clk) begin
        if (vld_d[i]) begin
          rem_q <= rem_d;
        end
      end

      assign out_rem = rem_q;
`endif
    end
  end

  assign out_data = q_s[n-1];

endmodule

// File: tb/tb_isqrt_pipe_with_valid.sv
// Bench for isqrt_pipe_with_valid: directed scenarios plus a randomized scoreboard run.
// Remainder checks are active when ISQRT_REMAINDER_EN is defined.
module tb_isqrt_pipe_with_valid;
  localparam int W = 32;
  localparam int N = W / 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_vld;
  logic [W-1:0] in_data;
  logic         out_vld;
  logic [N-1:0] out_data;
`ifdef ISQRT_REMAINDER_EN
  logic [N:0]   out_rem;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [N-1:0] exp_q[$];
  logic [N:0]   exp_rem_q[$];
  int           exp_at_q[$];

  always #5 clk = ~clk;

  isqrt_pipe_with_valid #(.width(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_data  (in_data),
    .out_vld  (out_vld),
    .out_data (out_data)
`ifdef ISQRT_REMAINDER_EN
    ,
    .out_rem  (out_rem)
`endif
  );

  function automatic longint ref_root(input longint x);
    longint r;
    r = longint'($sqrt(real'(x)));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Drive one cycle of input, then sample 1 time unit after the rising edge.
  task automatic tick(input logic v, input logic [W-1:0] x);
    in_vld  = v;
    in_data = x;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_vld = 1'b0; in_data = '0;
    #1;
    n_cmp++;
    if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", out_vld); end
    tick(1'b1, 32'd25);
    tick(1'b1, 32'd36);
    rst = 1'b0;
    for (int k = 0; k < N + 2; k++) begin
      tick(1'b0, '0);
      n_cmp++;
      if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_idle_vld: cycle %0d got %b expected 0", k, out_vld); end
    end
  endtask

  task automatic test_boundaries();
    logic         vin[3]   = '{1'b1, 1'b0, 1'b1};
    logic [W-1:0] xin[3]   = '{32'd0, 32'd123, 32'hFFFF_FFFF};
    logic [N-1:0] exp_d[3] = '{16'h0000, 16'h0000, 16'hFFFF};
    logic [N:0]   exp_r[3] = '{17'h00000, 17'h00000, 17'h1FFFE};
    int t0, idx;
    t0 = cyc + 1;
    for (int j = 0; j < 3; j++) tick(vin[j], xin[j]);
    for (int k = 0; k < N + 3; k++) begin
      tick(1'b0, W'($urandom));
      idx = cyc - (t0 + N - 1);
      n_cmp++;
      if (out_vld !== ((idx >= 0 && idx < 3) ? vin[idx] : 1'b0)) begin
        n_fail++; $display("FAIL bound_vld: idx %0d got %b", idx, out_vld);
      end
      if (idx >= 0 && idx < 3 && vin[idx]) begin
        n_cmp++;
        if (out_data !== exp_d[idx]) begin n_fail++; $display("FAIL bound_data: idx %0d got %0h expected %0h", idx, out_data, exp_d[idx]); end
`ifdef ISQRT_REMAINDER_EN
        n_cmp++;
        if (out_rem !== exp_r[idx]) begin n_fail++; $display("FAIL bound_rem: idx %0d got %0h expected %0h", idx, out_rem, exp_r[idx]); end
`endif
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xin[4]   = '{32'd4, 32'd9, 32'd15, 32'd16};
    logic [N-1:0] exp_d[4] = '{16'd2, 16'd3, 16'd3, 16'd4};
    logic [N:0]   exp_r[4] = '{17'd0, 17'd0, 17'd6, 17'd0};
    int t0, idx;
    t0 = cyc + 1;
    for (int j = 0; j < 4; j++) tick(1'b1, xin[j]);
    for (int k = 0; k < N + 2; k++) begin
      tick(1'b0, '0);
      idx = cyc - (t0 + N - 1);
      n_cmp++;
      if (out_vld !== (idx >= 0 && idx < 4)) begin n_fail++; $display("FAIL b2b_vld: idx %0d got %b", idx, out_vld); end
      if (idx >= 0 && idx < 4) begin
        n_cmp++;
        if (out_data !== exp_d[idx]) begin n_fail++; $display("FAIL b2b_data: idx %0d got %0d expected %0d", idx, out_data, exp_d[idx]); end
`ifdef ISQRT_REMAINDER_EN
        n_cmp++;
        if (out_rem !== exp_r[idx]) begin n_fail++; $display("FAIL b2b_rem: idx %0d got %0d expected %0d", idx, out_rem, exp_r[idx]); end
`endif
      end
    end
  endtask

  task automatic test_bubbles();
    logic         vin[6]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] xin[6]   = '{32'd100, 32'd7, 32'd7, 32'd1000000, 32'd7, 32'd2};
    logic [N-1:0] exp_d[6] = '{16'd10, 16'd10, 16'd10, 16'd1000, 16'd1000, 16'd1};
    logic [N:0]   exp_r[6] = '{17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd1};
    int t0, idx;
    t0 = cyc + 1;
    for (int j = 0; j < 6; j++) tick(vin[j], xin[j]);
    for (int k = 0; k < N + 2; k++) begin
      tick(1'b0, 32'd7);
      idx = cyc - (t0 + N - 1);
      n_cmp++;
      if (out_vld !== ((idx >= 0 && idx < 6) ? vin[idx] : 1'b0)) begin
        n_fail++; $display("FAIL bubble_vld: idx %0d got %b", idx, out_vld);
      end
      if (idx >= 0 && idx < 6) begin
        n_cmp++;
        if (out_data !== exp_d[idx]) begin n_fail++; $display("FAIL bubble_data: idx %0d got %0d expected %0d", idx, out_data, exp_d[idx]); end
`ifdef ISQRT_REMAINDER_EN
        n_cmp++;
        if (out_rem !== exp_r[idx]) begin n_fail++; $display("FAIL bubble_rem: idx %0d got %0d expected %0d", idx, out_rem, exp_r[idx]); end
`endif
      end
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    // Five operands, then an asynchronous reset in the middle of cycle 8.
    for (int j = 0; j < 5; j++) tick(1'b1, 32'd81);
    tick(1'b0, '0);
    tick(1'b0, '0);
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if (out_vld !== 1'b0) begin n_fail++; $display("FAIL rmid_drop: got %b expected 0", out_vld); end
    tick(1'b0, '0);
    rst = 1'b0;
    for (int k = 0; k < N + 2; k++) begin
      tick(1'b0, '0);
      n_cmp++;
      if (out_vld !== 1'b0) begin n_fail++; $display("FAIL rmid_flush: cycle %0d got %b expected 0", k, out_vld); end
    end
    // Reset while results are actively streaming out.
    for (int j = 0; j < N + 4; j++) tick(1'b1, 32'd81);
    n_cmp++;
    if (out_vld !== 1'b1 || out_data !== 16'd9) begin
      n_fail++; $display("FAIL rmid_stream: got vld %b data %0d expected vld 1 data 9", out_vld, out_data);
    end
    in_vld = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (out_vld !== 1'b0) begin n_fail++; $display("FAIL rmid_async: got %b expected 0", out_vld); end
    tick(1'b0, '0);
    rst = 1'b0;
    for (int k = 0; k < N + 2; k++) begin
      tick(1'b0, '0);
      n_cmp++;
      if (out_vld !== 1'b0) begin n_fail++; $display("FAIL rmid_discard: cycle %0d got %b expected 0", k, out_vld); end
    end
    tick(1'b1, 32'd49);
    t0 = cyc;
    for (int k = 0; k < N + 2; k++) begin
      tick(1'b0, '0);
      n_cmp++;
      if (out_vld !== (cyc == t0 + N - 1)) begin n_fail++; $display("FAIL rmid_49_vld: cycle %0d got %b", cyc - t0, out_vld); end
      if (cyc == t0 + N - 1) begin
        n_cmp++;
        if (out_data !== 16'd7) begin n_fail++; $display("FAIL rmid_49_data: got %0d expected 7", out_data); end
      end
    end
  endtask

  task automatic test_random();
    int           dens[4] = '{100, 60, 25, 90};
    logic         v;
    logic [W-1:0] x;
    logic [15:0]  s;
    longint       root;
    logic [N-1:0] last_d;
    logic [N:0]   last_r;
    logic         have_last;
    int           sel;
    have_last = 1'b0;
    last_d = '0;
    last_r = '0;
    exp_q.delete(); exp_rem_q.delete(); exp_at_q.delete();
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 1000; k++) begin
        v   = (p < 4) ? ($urandom_range(99) < dens[p]) : 1'b0;
        sel = $urandom_range(9);
        s   = 16'($urandom);
        x   = (sel == 0) ? '0 : (sel == 1) ? '1 : (sel == 2) ? W'(s) * W'(s) : W'($urandom);
        tick(v, x);
        if (v) begin
          root = ref_root(longint'(x));
          exp_q.push_back(N'(root));
          exp_rem_q.push_back((N+1)'(longint'(x) - root * root));
          exp_at_q.push_back(cyc + N - 1);
        end
        if (exp_at_q.size() != 0 && exp_at_q[0] == cyc) begin
          n_cmp++;
          if (out_vld !== 1'b1) begin n_fail++; $display("FAIL rnd_vld: cycle %0d got %b expected 1", cyc, out_vld); end
          n_cmp++;
          if (out_data !== exp_q[0]) begin n_fail++; $display("FAIL rnd_data: cycle %0d got %0h expected %0h", cyc, out_data, exp_q[0]); end
`ifdef ISQRT_REMAINDER_EN
          n_cmp++;
          if (out_rem !== exp_rem_q[0]) begin n_fail++; $display("FAIL rnd_rem: cycle %0d got %0h expected %0h", cyc, out_rem, exp_rem_q[0]); end
`endif
          last_d = exp_q.pop_front();
          last_r = exp_rem_q.pop_front();
          void'(exp_at_q.pop_front());
          have_last = 1'b1;
        end else begin
          n_cmp++;
          if (out_vld !== 1'b0) begin n_fail++; $display("FAIL rnd_vld: cycle %0d got %b expected 0", cyc, out_vld); end
          if (have_last) begin
            n_cmp++;
            if (out_data !== last_d) begin n_fail++; $display("FAIL rnd_hold: cycle %0d got %0h expected %0h", cyc, out_data, last_d); end
`ifdef ISQRT_REMAINDER_EN
            n_cmp++;
            if (out_rem !== last_r) begin n_fail++; $display("FAIL rnd_hold_rem: cycle %0d got %0h expected %0h", cyc, out_rem, last_r); end
`endif
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_boundaries();
    test_back_to_back();
    test_bubbles();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
